// File: rtl/speles_pkg.sv
// Shared definitions for the round timer and the game-logic block:
// timer FSM encodings, the seconds width and the game-state encodings.
package speles_pkg;

  localparam int TIME_W = 5;

  localparam logic [1:0] T_IDLE    = 2'b00;
  localparam logic [1:0] T_RUN     = 2'b01;
  localparam logic [1:0] T_EXPIRED = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE    = T_IDLE,
    ST_RUN     = T_RUN,
    ST_EXPIRED = T_EXPIRED
  } t_state_e;

  typedef enum logic [1:0] {
    G_WAIT = 2'b00,
    G_PLAY = 2'b01,
    G_OVER = 2'b10
  } game_state_e;

endpackage

// File: rtl/speles_tick_gen.sv
// One-second tick generator: counts enabled cycles and pulses tick on the
// last count of each CLK_DIV-cycle period; clr restarts the period.
module speles_tick_gen #(
  parameter int CLK_DIV = 50000000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic tick
);

  localparam int CNT_W = $clog2(CLK_DIV);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CLK_DIV - 1);

  logic [CNT_W-1:0] cnt_r;

  assign tick = en & (cnt_r == CNT_MAX);

  // Period counter; holds while disabled so partial seconds survive a pause.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r <= {CNT_W{1'b0}};
    end else if (clr) begin
      cnt_r <= {CNT_W{1'b0}};
    end else if (tick) begin
      cnt_r <= {CNT_W{1'b0}};
    end else if (en) begin
      cnt_r <= cnt_r + CNT_W'(1'b1);
    end else begin
      cnt_r <= cnt_r;
    end
  end

endmodule

// File: rtl/speles_taimeris.sv
// Round countdown timer: arms on a time_f rising edge, counts seconds down
// while g_enable is high and raises end_f on expiry. Optional warn blinking
// is enabled with the TIMER_WARN_BLINK_EN macro.
module speles_taimeris
  import speles_pkg::*;
#(
  parameter int CLK_DIV   = 50000000,
  parameter int WARN_SEC  = 5,
  parameter int BLINK_DIV = 12500000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       time_f,
  input  logic [0:4] time_v,
  input  logic       g_enable,
  output logic       end_f,
  output logic [0:4] remaining,
  output logic       warn,
  output logic [0:1] t_state
);

  if (CLK_DIV < 2 || BLINK_DIV < 2) begin : g_bad_param
    $error("speles_taimeris: CLK_DIV and BLINK_DIV must be >= 2");
  end

  localparam logic [TIME_W-1:0] WARN_LIM = TIME_W'(WARN_SEC);

  t_state_e          state_r, state_n;
  logic [TIME_W-1:0] rem_r, rem_n;
  logic              end_r, end_n;
  logic              warn_r;
  logic              time_f_q_r;
  logic              rise_s;
  logic              tick_s;
  logic              tick_clr_s;
  logic              tick_en_s;
  logic              warn_cond_s;

  assign rise_s     = time_f & ~time_f_q_r;
  assign tick_clr_s = rise_s | (state_r != ST_RUN);
  assign tick_en_s  = (state_r == ST_RUN) & g_enable & time_f;

  speles_tick_gen #(
    .CLK_DIV(CLK_DIV)
  ) u_tick_gen (
    .clk  (clk),
    .rst_n(rst_n),
    .clr  (tick_clr_s),
    .en   (tick_en_s),
    .tick (tick_s)
  );

  // Next-state logic; an arm edge outranks abort and expiry.
  always_comb begin
    state_n = state_r;
    rem_n   = rem_r;
    end_n   = end_r;
    if (rise_s) begin
      rem_n = time_v;
      if (time_v == 5'd0) begin
        state_n = ST_EXPIRED;
        end_n   = 1'b1;
      end else begin
        state_n = ST_RUN;
        end_n   = 1'b0;
      end
    end else begin
      case (state_r)
        ST_IDLE: begin
          end_n = 1'b0;
        end
        ST_RUN: begin
          if (!time_f) begin
            state_n = ST_IDLE;
            end_n   = 1'b0;
          end else if (tick_s && (rem_r != 5'd0)) begin
            rem_n = rem_r - 5'd1;
            if (rem_r == 5'd1) begin
              state_n = ST_EXPIRED;
              end_n   = 1'b1;
            end else begin
              end_n = 1'b0;
            end
          end else begin
            end_n = 1'b0;
          end
        end
        ST_EXPIRED: begin
          rem_n = 5'd0;
          if (!time_f) begin
            state_n = ST_IDLE;
            end_n   = 1'b0;
          end else begin
            end_n = 1'b1;
          end
        end
        default: begin
          state_n = ST_IDLE;
          rem_n   = 5'd0;
          end_n   = 1'b0;
        end
      endcase
    end
  end

  assign warn_cond_s = (state_n == ST_RUN) & (rem_n <= WARN_LIM) & (rem_n != 5'd0);

  // FSM, countdown and arm-edge registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= ST_IDLE;
      rem_r      <= 5'd0;
      end_r      <= 1'b0;
      time_f_q_r <= 1'b0;
    end else begin
      state_r    <= state_n;
      rem_r      <= rem_n;
      end_r      <= end_n;
      time_f_q_r <= time_f;
    end
  end

`ifdef TIMER_WARN_BLINK_EN
  localparam int BL_W = $clog2(BLINK_DIV);
  localparam logic [BL_W-1:0] BL_MAX = BL_W'(BLINK_DIV - 1);

  logic [BL_W-1:0] blink_cnt_r;
  logic            warn_cond_r;

  // Blink generator: starts high on entry, toggles each BLINK_DIV running cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      warn_r      <= 1'b0;
      warn_cond_r <= 1'b0;
      blink_cnt_r <= {BL_W{1'b0}};
    end else begin
      warn_cond_r <= warn_cond_s;
      if (!warn_cond_s) begin
        warn_r      <= 1'b0;
        blink_cnt_r <= {BL_W{1'b0}};
      end else if (!warn_cond_r) begin
        warn_r      <= 1'b1;
        blink_cnt_r <= {BL_W{1'b0}};
      end else if (g_enable) begin
        if (blink_cnt_r == BL_MAX) begin
          blink_cnt_r <= {BL_W{1'b0}};
          warn_r      <= ~warn_r;
        end else begin
          blink_cnt_r <= blink_cnt_r + BL_W'(1'b1);
        end
      end else begin
        blink_cnt_r <= blink_cnt_r;
      end
    end
  end
`else
  // Steady warn level aligned with remaining.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      warn_r <= 1'b0;
    end else begin
      warn_r <= warn_cond_s;
    end
  end
`endif

  assign end_f     = end_r;
  assign remaining = rem_r;
  assign warn      = warn_r;
  assign t_state   = state_r;

endmodule

// File: tb/tb_speles_taimeris.sv
// Directed self-checking bench for speles_taimeris with CLK_DIV=4, WARN_SEC=5.
module tb_speles_taimeris;

  logic       clk;
  logic       rst_n;
  logic       time_f;
  logic [0:4] time_v;
  logic       g_enable;
  logic       end_f;
  logic [0:4] remaining;
  logic       warn;
  logic [0:1] t_state;

  int checks = 0;
  int errors = 0;

  speles_taimeris #(
    .CLK_DIV  (4),
    .WARN_SEC (5),
    .BLINK_DIV(2)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .time_f   (time_f),
    .time_v   (time_v),
    .g_enable (g_enable),
    .end_f    (end_f),
    .remaining(remaining),
    .warn     (warn),
    .t_state  (t_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  initial begin
    rst_n    = 1'b0;
    time_f   = 1'b0;
    time_v   = 5'd0;
    g_enable = 1'b1;
    #12;
    chk("rst_state", t_state, 0);
    chk("rst_rem", remaining, 0);
    chk("rst_end", end_f, 0);
    chk("rst_warn", warn, 0);
    step(1);
    rst_n = 1'b1;
    step(1);
    chk("idle_state", t_state, 0);

    // Scenario 1: budget 3, no pause
    time_v = 5'd3; time_f = 1'b1;
    step(1);
    chk("s1_rem3", remaining, 3);
    chk("s1_run", t_state, 1);
    chk("s1_end0", end_f, 0);
    chk("s1_warn3", warn, 1);
    step(3);
    chk("s1_rem3_hold", remaining, 3);
    step(1);
    chk("s1_rem2", remaining, 2);
    step(4);
    chk("s1_rem1", remaining, 1);
    step(3);
    chk("s1_end_pre", end_f, 0);
    step(1);
    chk("s1_rem0", remaining, 0);
    chk("s1_end1", end_f, 1);
    chk("s1_exp", t_state, 2);
    chk("s1_warn0", warn, 0);
    step(3);
    chk("s1_end_held", end_f, 1);

    // Scenario 2: drop, then re-arm with 2
    time_f = 1'b0;
    step(1);
    chk("s2_idle", t_state, 0);
    chk("s2_end0", end_f, 0);
    time_v = 5'd2; time_f = 1'b1;
    step(1);
    chk("s2_run", t_state, 1);
    chk("s2_rem2", remaining, 2);
    step(2);
    time_f = 1'b0;
    step(1);
    chk("abort_idle", t_state, 0);
    chk("abort_rem_hold", remaining, 2);
    chk("abort_end0", end_f, 0);

    // Scenario 3: pause 10 cycles mid-second
    time_v = 5'd3; time_f = 1'b1;
    step(1);
    chk("s3_rem3", remaining, 3);
    step(2);
    g_enable = 1'b0;
    step(10);
    chk("s3_frozen_rem", remaining, 3);
    chk("s3_frozen_run", t_state, 1);
    g_enable = 1'b1;
    step(1);
    chk("s3_rem3_last", remaining, 3);
    step(1);
    chk("s3_rem2", remaining, 2);
    step(7);
    chk("s3_end_pre", end_f, 0);
    step(1);
    chk("s3_end1", end_f, 1);
    chk("s3_exp", t_state, 2);
    time_f = 1'b0;
    step(1);

    // Scenario 4: zero budget expires immediately
    time_v = 5'd0; time_f = 1'b1;
    step(1);
    chk("s4_end1", end_f, 1);
    chk("s4_exp", t_state, 2);
    chk("s4_rem0", remaining, 0);
    chk("s4_warn0", warn, 0);
    time_f = 1'b0;
    step(1);
    chk("s4_idle", t_state, 0);

    // Scenario 5: reset mid-run
    time_v = 5'd3; time_f = 1'b1;
    step(1);
    step(4);
    chk("s5_rem2", remaining, 2);
    #2;
    rst_n = 1'b0;
    #1;
    chk("s5_rst_state", t_state, 0);
    chk("s5_rst_rem", remaining, 0);
    chk("s5_rst_end", end_f, 0);
    chk("s5_rst_warn", warn, 0);
    step(2);
    time_f = 1'b0;
    rst_n  = 1'b1;
    step(12);
    chk("s5_post_state", t_state, 0);
    chk("s5_post_end", end_f, 0);

    // Scenario 6: warn window with budget 7
    time_v = 5'd7; time_f = 1'b1;
    step(1);
    chk("s6_rem7", remaining, 7);
    chk("s6_warn_7", warn, 0);
    step(4);
    chk("s6_rem6", remaining, 6);
    chk("s6_warn_6", warn, 0);
    step(4);
    chk("s6_rem5", remaining, 5);
    chk("s6_warn_5", warn, 1);
`ifdef TIMER_WARN_BLINK_EN
    step(2);
    chk("s6_blink_low", warn, 0);
    step(14);
`else
    step(16);
`endif
    chk("s6_rem1", remaining, 1);
    chk("s6_warn_1", warn, 1);
    step(4);
    chk("s6_rem0", remaining, 0);
    chk("s6_warn_exp", warn, 0);
    chk("s6_end1", end_f, 1);
    time_f = 1'b0;
    step(1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/speles_taimeris.md
Name: speles_taimeris

Overview:
Round countdown timer directly downstream of the game-logic block. It consumes the game logic's time_f arm flag, time_v seconds budget and g_enable run/pause qualifier, and produces end_f, which feeds back into the game logic's end_f input. It also exposes the remaining seconds and a low-time warning for the display path.

Parameters:
CLK_DIV, 50000000, clock cycles per one-second tick; must be >= 2; benches override it to 4.
WARN_SEC, 5, warn is asserted while remaining <= WARN_SEC and remaining > 0.
BLINK_DIV, 12500000, half-period in clock cycles of the warn blink; used only with TIMER_WARN_BLINK_EN.

Ports:
clk  in  1  system clock; the single clock domain.
rst_n  in  1  asynchronous, active-low reset.
time_f  in  1  arm flag from game logic; a rising edge loads the budget.
time_v  in  [0:4]  seconds budget from game logic, 0..31; bit 0 is the MSB.
g_enable  in  1  1 = count, 0 = pause (tick counter and remaining both freeze).
end_f  out  1  round expired; held high until time_f falls.
remaining  out  [0:4]  seconds left; bit 0 is the MSB.
warn  out  1  low-time warning.
t_state  out  [0:1]  debug copy of the FSM state.

Behaviour:
- Reset (asynchronous on rst_n low):
  - t_state = IDLE (00); remaining = 0; end_f = 0; warn = 0.
  - Tick counter = 0; time_f edge register = 0.
  - Reset asserted mid-run aborts the run immediately; no end_f is produced.
- Edge detection: time_f is registered every cycle; rise = time_f & ~time_f_q.
- FSM states: IDLE = 00, RUN = 01, EXPIRED = 10. Encoding 11 is illegal and is forced to IDLE on the next cycle.
- Any state, rise sampled at clock edge N:
  - At N+1: remaining = time_v, tick counter = 0, end_f = 0.
  - If time_v != 0: state = RUN at N+1.
  - If time_v == 0: state = EXPIRED and end_f = 1 at N+1.
  - rise has priority over every other event in the same cycle, including an expiry tick. This allows a re-arm from EXPIRED or a restart from RUN.
- RUN with g_enable = 1:
  - Tick counter increments each cycle.
  - When the counter reaches CLK_DIV-1 it wraps to 0 and remaining decrements on that same edge.
  - The decrement that takes remaining from 1 to 0 also sets end_f = 1 and state = EXPIRED on that edge.
- RUN with g_enable = 0: counter and remaining hold; partial-second progress is kept.
- RUN when time_f falls: state returns to IDLE; remaining holds its value (abort).
- EXPIRED: remaining = 0 and end_f = 1. When time_f is seen low, state returns to IDLE and end_f = 0 on the next edge.
- IDLE: end_f = 0 and the counter is idle. A time_f level that is already high without a fresh edge does nothing.
- Latency: with budget T > 0 and no pause, end_f rises at edge N + 1 + T*CLK_DIV.
- warn is registered:
  - Equals (state == RUN) & (remaining <= WARN_SEC) & (remaining != 0), evaluated on next-state values, so it is aligned with remaining.
  - warn = 0 in IDLE and EXPIRED.
- Arithmetic:
  - remaining is 5-bit unsigned and never underflows; a decrement is only taken when remaining != 0.
  - Tick counter is $clog2(CLK_DIV) bits wide.

Optional Feature:
Macro TIMER_WARN_BLINK_EN.
- Defined: warn toggles every BLINK_DIV cycles while the warn condition holds.
  - The blink counter restarts at each entry into the warn condition, and warn goes high immediately on entry.
  - warn = 0 whenever the condition is false.
  - Blinking also freezes while g_enable = 0.
- Undefined: warn is the steady level described above. The blink counter and BLINK_DIV logic are absent.

Decomposition:
- Package speles_pkg holds:
  - FSM encodings T_IDLE, T_RUN, T_EXPIRED as 2-bit localparams.
  - TIME_W = 5.
  - The shared game-state encodings also used by the game-logic block.
- One sub-module, speles_tick_gen: parameter CLK_DIV; ports clk, rst_n, clr, en; output tick, a one-cycle pulse asserted when the counter is at CLK_DIV-1 and en = 1.
- The FSM, remaining register and warn logic stay in the top module.

Test Plan:
1. CLK_DIV=4, time_v=3, g_enable=1, time_f rises at edge N -> remaining reads 3,2,1,0 at N+1, N+5, N+9, N+13; end_f=1 from N+13; t_state=10.
2. Expired, then time_f dropped at edge M -> t_state=00 and end_f=0 at M+1; re-raising time_f with time_v=2 -> RUN with remaining=2.
3. time_v=3, g_enable=0 for 10 cycles mid-second -> remaining is frozen; end_f is delayed by exactly 10 cycles versus scenario 1.
4. time_v=0 with a time_f rise -> end_f=1 and t_state=10 one cycle later; remaining=0; warn never asserts.
5. rst_n pulsed low during RUN with remaining=2 -> all outputs go to 0 asynchronously; end_f never asserts; after release, t_state=00.
6. WARN_SEC=5, time_v=7 -> warn=0 while remaining is 7 or 6; warn=1 while remaining is 5..1; warn=0 at expiry. With TIMER_WARN_BLINK_EN defined and BLINK_DIV=2, warn toggles every 2 cycles during that window.
